// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: credit-limited sequential fetch, in-order response FIFO, redirect flush.
// Optional performance counters are compiled in with `define IFETCH_QUEUE_PERF_EN.
module ifetch_queue #(
  parameter int             AW       = 32,
  parameter int             DW       = 32,
  parameter int             DEPTH    = 4,
  parameter logic [AW-1:0]  RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  output logic          req_valid,
  input  logic          req_ready,
  output logic [AW-1:0] req_addr,
  input  logic          resp_valid,
  input  logic [DW-1:0] resp_instr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_pc,
  output logic [DW-1:0] out_instr,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc
`ifdef IFETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]   perf_fetch_cnt,
  output logic [31:0]   perf_flush_cnt,
  output logic [31:0]   perf_starve_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_V = (CW+1)'(DEPTH);

  logic [AW-1:0] r_fetch_pc;
  logic [AW-1:0] r_pc_mem    [DEPTH];
  logic [DW-1:0] r_instr_mem [DEPTH];
  logic [AW-1:0] r_pend_mem  [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr, r_pend_wr, r_pend_rd;
  logic [CW-1:0] r_count, r_outstanding, r_discard;

  logic [CW:0]   w_inflight;
  logic          w_req_fire;
  logic          w_discarding;
  logic          w_resp_keep;
  logic          w_pop;
  logic          w_unused_ok;

  // Credit covers buffered entries plus every in-flight fetch, stale ones included.
  assign w_inflight   = {1'b0, r_count} + {1'b0, r_outstanding};
  assign req_valid    = rst && (w_inflight < DEPTH_V) && !redirect_valid;
  assign req_addr     = r_fetch_pc;
  assign w_req_fire   = req_valid && req_ready;
  assign w_discarding = (r_discard != '0);
  assign w_resp_keep  = resp_valid && !w_discarding;

  assign out_valid    = (r_count != '0);
  assign out_pc       = out_valid ? r_pc_mem[r_rd_ptr]    : '0;
  assign out_instr    = out_valid ? r_instr_mem[r_rd_ptr] : '0;
  assign w_pop        = out_valid && out_ready;

  assign w_unused_ok  = &{1'b1, redirect_pc[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc    <= RESET_PC;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_pend_wr     <= '0;
      r_pend_rd     <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight becomes stale; a response landing now is already dropped.
      r_fetch_pc    <= {redirect_pc[AW-1:2], 2'b00};
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_pend_wr     <= '0;
      r_pend_rd     <= '0;
      r_count       <= '0;
      r_outstanding <= r_outstanding - CW'(resp_valid);
      r_discard     <= r_outstanding - CW'(resp_valid);
    end else begin
      if (w_req_fire) begin
        r_pend_wr  <= r_pend_wr + PW'(1);
        r_fetch_pc <= r_fetch_pc + AW'(4);
      end
      if (w_resp_keep) begin
        r_pend_rd <= r_pend_rd + PW'(1);
        r_wr_ptr  <= r_wr_ptr + PW'(1);
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PW'(1);
      if (resp_valid && w_discarding)
        r_discard <= r_discard - CW'(1);
      r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(resp_valid);
      r_count       <= r_count + CW'(w_resp_keep) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_req_fire)
      r_pend_mem[r_pend_wr] <= r_fetch_pc;
    if (w_resp_keep && !redirect_valid) begin
      r_pc_mem[r_wr_ptr]    <= r_pend_mem[r_pend_rd];
      r_instr_mem[r_wr_ptr] <= resp_instr;
    end
  end

`ifdef IFETCH_QUEUE_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_cnt  <= '0;
      perf_flush_cnt  <= '0;
      perf_starve_cnt <= '0;
    end else begin
      if (w_req_fire)
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (redirect_valid)
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      if (out_ready && !out_valid)
        perf_starve_cnt <= perf_starve_cnt + 32'd1;
    end
  end
`endif

endmodule
